wavelet_mac_scheduler: RTL and testbench
========================================

# wavelet_mac_scheduler

- Sequencer for a single shared multiply-accumulate (MAC) unit that computes all Ricker-wavelet FIR channels in time-multiplexed order. It replaces eight parallel FIR adder trees.
- Per input sample it:
  - synchronises the external data strobe,
  - pulses the shift-register line,
  - walks the MAC through every tap of every filter in turn,
  - strobes each channel's result into the output register bank.
- It sits between the pad-level `i_data_clk` input, the shift register line, the shared MAC/coefficient ROM and the output multiplexer.

## Interface

Parameters:
- `NUM_FILTERS`, 8: number of filter channels sequenced per sample.
- `TAP_IDX_BITS`, 8: width of the tap index and of each length field.
- `FILTER_LENS`, 64'h8D51_2F1B_0F09_0503: packed tap counts, filter 0 in the LSB byte (3, 5, 9, 15, 27, 47, 81, 141).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `i_data_clk` in 1: asynchronous sample strobe from pad; the rising edge marks a new sample.
- `i_enable` in 1: when low, new samples are not accepted.
- `o_shift` out 1: one-cycle pulse that shifts the new sample into the tap line.
- `o_filter_sel` out 3: index of the filter the MAC is currently serving.
- `o_tap_idx` out TAP_IDX_BITS: tap and coefficient index for the current MAC cycle.
- `o_mac_clear` out 1: zero the accumulator.
- `o_mac_en` out 1: accumulate `tap[o_tap_idx] * coeff[o_filter_sel][o_tap_idx]`.
- `o_mac_store` out 1: latch the truncated accumulator into output channel `o_filter_sel`.
- `o_busy` out 1: high in every state except IDLE.
- `o_frame_done` out 1: one-cycle pulse after the last channel is stored.
- `o_overrun_count` out 8: saturating count of dropped samples.

## Operation

- **Synchroniser**
  - Three flops s1 → s2 → s3 on `i_data_clk`.
  - `rise = s2 & ~s3`.
  - All three flops reset to 0.
- **FSM states:** IDLE, SHIFT, CLEAR, RUN, STORE, DONE. Filter counter `f` and tap counter `t`.
- **IDLE**
  - If `rise & i_enable`: go to SHIFT, set `f = 0`.
  - If `rise & ~i_enable`: ignore, nothing counted.
- **SHIFT:** `o_shift = 1` for one cycle, then go to CLEAR.
- **CLEAR**
  - `o_mac_clear = 1`, `o_filter_sel = f`, `o_tap_idx = 0`, `t = 0`.
  - Next state is RUN if `len[f] != 0`, otherwise STORE.
- **RUN**
  - `o_mac_en = 1`, `o_tap_idx = t`, `t` increments each cycle.
  - When `t == len[f] - 1`, go to STORE next.
  - Occupies exactly `len[f]` cycles.
- **STORE**
  - `o_mac_store = 1`, `o_filter_sel = f`.
  - If `f == NUM_FILTERS - 1`: go to DONE.
  - Otherwise: `f <= f + 1`, go to CLEAR.
- **DONE:** `o_frame_done = 1` for one cycle, then go to IDLE.
- **Overrun**
  - A `rise` while the state is not IDLE (including DONE) is an overrun.
  - The sample is dropped: no `o_shift`, and the frame in progress is unaffected.
  - `o_overrun_count` increments and saturates at 255.
- **`i_enable` deasserted mid-frame:** the current frame completes normally; only new frames are blocked.
- **Strobe outputs:** `o_mac_clear`, `o_mac_en`, `o_mac_store`, `o_shift` and `o_frame_done` are mutually exclusive.
- **Idle values:** `o_tap_idx` and `o_filter_sel` are 0 when not meaningful (IDLE, SHIFT, DONE).
- **Registering:** all outputs are registered, decoded from the state and counter registers.

## Timing

- **Reset values:** every output is 0, state is IDLE, `f = t = 0`, synchroniser is 0, `o_overrun_count = 0`.
- **Reset mid-frame:** return to IDLE on the next edge and drop the partial frame; no `o_mac_store` or `o_frame_done` is issued.
- **Input latency:** if `i_data_clk` is first sampled high at edge k, then:
  - `rise` is high during the cycle after edge k+2,
  - SHIFT is entered at edge k+3,
  - `o_shift` is high between edges k+3 and k+4.
- **Frame length:** SHIFT 1 + Σ(len+2) + DONE 1. With the defaults this is 1 + 328 + 16 + 1 = 346 cycles.
- **Earliest next sample:** the first rise seen in IDLE, i.e. the cycle after DONE.
- **Sample period:** the strobe must stay high and low for at least 2 clk cycles each; shorter pulses may be missed, and this is allowed.
- **Simultaneous events**
  - A rise in the same cycle the FSM moves DONE → IDLE counts as an overrun; the state is DONE in that cycle.
  - Reset has priority over every other event.

## Test plan

- **Single sample, defaults.**
  - Stimulus: reset, `i_enable = 1`, one rising edge.
  - Response: exactly one `o_shift`, then 8 stores with `o_filter_sel` 0..7.
  - `o_mac_en` counts are 3, 5, 9, 15, 27, 47, 81, 141, with `o_tap_idx` running 0..len-1 for each.
  - `o_frame_done` comes 346 cycles after `o_shift` rises; then the block is idle with `o_busy = 0`.
- **Overrun.**
  - Stimulus: a second edge 100 cycles into the frame, then a third edge.
  - Response: the second edge produces no extra `o_shift`, the frame completes unchanged and `o_overrun_count = 1`.
  - Response: 300 more edges during subsequent frames saturate the count at 255.
- **Enable gating.**
  - Stimulus: `i_enable = 0` with an edge.
  - Response: no activity, count stays 0.
  - Stimulus: drop `i_enable` mid-frame.
  - Response: the frame still ends with `o_frame_done`.
- **Reset mid-RUN.**
  - Stimulus: assert `rst` during filter 5, tap 20.
  - Response: all outputs are 0 on the next cycle, and no `o_mac_store` occurs for filter 5.
  - Stimulus: the next edge.
  - Response: a clean frame starting at filter 0.
- **Zero-length filter.**
  - Stimulus: `FILTER_LENS = 64'h0000_0000_0000_0300`.
  - Response: filter 0 gets CLEAR then STORE with no `o_mac_en`; filter 1 gets 3 MAC cycles.
  - Response: the frame is 1 + 16 + 3 + 1 = 21 cycles long.
- **Boundary edge.**
  - Stimulus: an edge timed so that `rise` coincides with the DONE cycle.
  - Response: it is counted as an overrun with no shift, and the following edge starts a normal frame.

Source files
------------

// File: rtl/wavelet_mac_scheduler.sv
// wavelet_mac_scheduler
// Sequences one shared multiply-accumulate unit through every tap of every
// Ricker-wavelet FIR channel for each incoming sample. The pad-level sample
// strobe is synchronised and edge-detected. Samples that arrive while a frame
// is still in flight are dropped and counted. Every output is a flop, decoded
// from the next-state and next-counter values so that each output lines up
// with the state it describes.
module wavelet_mac_scheduler #(
  parameter int NUM_FILTERS  = 8,
  parameter int TAP_IDX_BITS = 8,
  parameter logic [NUM_FILTERS*TAP_IDX_BITS-1:0] FILTER_LENS = 64'h8D51_2F1B_0F09_0503
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_data_clk,
  input  logic                    i_enable,
  output logic                    o_shift,
  output logic [2:0]              o_filter_sel,
  output logic [TAP_IDX_BITS-1:0] o_tap_idx,
  output logic                    o_mac_clear,
  output logic                    o_mac_en,
  output logic                    o_mac_store,
  output logic                    o_busy,
  output logic                    o_frame_done,
  output logic [7:0]              o_overrun_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_CLEAR = 3'd2,
    S_RUN   = 3'd3,
    S_STORE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [2:0]              LAST_F   = 3'(NUM_FILTERS - 1);
  localparam logic [2:0]              F_ONE    = 3'd1;
  localparam logic [2:0]              F_ZERO   = 3'd0;
  localparam logic [TAP_IDX_BITS-1:0] TAP_ONE  = TAP_IDX_BITS'(1);
  localparam logic [TAP_IDX_BITS-1:0] TAP_ZERO = TAP_IDX_BITS'(0);
  localparam logic [7:0]              OVR_MAX  = 8'hFF;
  localparam logic [7:0]              OVR_ONE  = 8'h01;

  // Synchroniser chain and the registered edge detect.
  logic sync1_r, sync2_r, sync3_r;
  logic rise_r;

  // Sequencer state and counters.
  state_t                  state_r, state_nxt_s;
  logic [2:0]              f_r, f_nxt_s;
  logic [TAP_IDX_BITS-1:0] t_r, t_nxt_s;

  // Values the outputs take in the next cycle.
  logic [2:0]              sel_nxt_s;
  logic [TAP_IDX_BITS-1:0] tap_nxt_s;

  // Per-filter tap counts, unpacked from the packed parameter.
  logic [TAP_IDX_BITS-1:0] len_tab_s [NUM_FILTERS];
  logic [TAP_IDX_BITS-1:0] cur_len_s;

  genvar g;
  generate
    for (g = 0; g < NUM_FILTERS; g++) begin : g_len
      assign len_tab_s[g] = FILTER_LENS[g*TAP_IDX_BITS +: TAP_IDX_BITS];
    end
  endgenerate

  assign cur_len_s = len_tab_s[f_r];

  // Three-flop synchroniser on the pad strobe; the edge detect is registered so the FSM sees a clean pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      sync1_r <= i_data_clk;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
      rise_r  <= sync2_r & ~sync3_r;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      f_r     <= F_ZERO;
      t_r     <= TAP_ZERO;
    end else begin
      state_r <= state_nxt_s;
      f_r     <= f_nxt_s;
      t_r     <= t_nxt_s;
    end
  end

  // Next-state and next-counter logic: walk every tap of every filter once per accepted sample.
  always_comb begin
    state_nxt_s = state_r;
    f_nxt_s     = f_r;
    t_nxt_s     = t_r;
    case (state_r)
      S_IDLE: begin
        if (rise_r && i_enable) begin
          state_nxt_s = S_SHIFT;
          f_nxt_s     = F_ZERO;
          t_nxt_s     = TAP_ZERO;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_SHIFT: begin
        state_nxt_s = S_CLEAR;
        t_nxt_s     = TAP_ZERO;
      end
      S_CLEAR: begin
        t_nxt_s = TAP_ZERO;
        if (cur_len_s != TAP_ZERO) begin
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_STORE;
        end
      end
      S_RUN: begin
        if (t_r == cur_len_s - TAP_ONE) begin
          state_nxt_s = S_STORE;
          t_nxt_s     = TAP_ZERO;
        end else begin
          t_nxt_s     = t_r + TAP_ONE;
        end
      end
      S_STORE: begin
        if (f_r == LAST_F) begin
          state_nxt_s = S_DONE;
          f_nxt_s     = F_ZERO;
        end else begin
          state_nxt_s = S_CLEAR;
          f_nxt_s     = f_r + F_ONE;
        end
      end
      S_DONE: begin
        state_nxt_s = S_IDLE;
        f_nxt_s     = F_ZERO;
        t_nxt_s     = TAP_ZERO;
      end
      default: begin
        state_nxt_s = S_IDLE;
        f_nxt_s     = F_ZERO;
        t_nxt_s     = TAP_ZERO;
      end
    endcase
  end

  // Filter select and tap index carry meaning only while the MAC serves a filter; they read 0 otherwise.
  always_comb begin
    sel_nxt_s = F_ZERO;
    tap_nxt_s = TAP_ZERO;
    case (state_nxt_s)
      S_CLEAR: begin
        sel_nxt_s = f_nxt_s;
        tap_nxt_s = TAP_ZERO;
      end
      S_RUN: begin
        sel_nxt_s = f_nxt_s;
        tap_nxt_s = t_nxt_s;
      end
      S_STORE: begin
        sel_nxt_s = f_nxt_s;
        tap_nxt_s = TAP_ZERO;
      end
      default: begin
        sel_nxt_s = F_ZERO;
        tap_nxt_s = TAP_ZERO;
      end
    endcase
  end

  // Registered strobes and indices; decoding one next-state value keeps the strobes mutually exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_shift      <= 1'b0;
      o_mac_clear  <= 1'b0;
      o_mac_en     <= 1'b0;
      o_mac_store  <= 1'b0;
      o_frame_done <= 1'b0;
      o_busy       <= 1'b0;
      o_filter_sel <= F_ZERO;
      o_tap_idx    <= TAP_ZERO;
    end else begin
      o_shift      <= (state_nxt_s == S_SHIFT);
      o_mac_clear  <= (state_nxt_s == S_CLEAR);
      o_mac_en     <= (state_nxt_s == S_RUN);
      o_mac_store  <= (state_nxt_s == S_STORE);
      o_frame_done <= (state_nxt_s == S_DONE);
      o_busy       <= (state_nxt_s != S_IDLE);
      o_filter_sel <= sel_nxt_s;
      o_tap_idx    <= tap_nxt_s;
    end
  end

  // Count samples that arrive while a frame is in flight (DONE included); saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_overrun_count <= 8'h00;
    end else if (rise_r && (state_r != S_IDLE) && (o_overrun_count != OVR_MAX)) begin
      o_overrun_count <= o_overrun_count + OVR_ONE;
    end else begin
      o_overrun_count <= o_overrun_count;
    end
  end

endmodule

// File: tb/tb_wavelet_mac_scheduler.sv
// Directed bench for wavelet_mac_scheduler. Inputs are driven and outputs
// sampled on the falling clock edge. A second instance with a zero-length
// filter shares all inputs with the default instance.
module tb_wavelet_mac_scheduler;

  logic clk = 1'b0;
  logic rst;
  logic i_data_clk;
  logic i_enable;

  logic       a_shift, a_clear, a_en, a_store, a_busy, a_done;
  logic [2:0] a_sel;
  logic [7:0] a_tap, a_ovr;
  logic       z_shift, z_clear, z_en, z_store, z_busy, z_done;
  logic [2:0] z_sel;
  logic [7:0] z_tap, z_ovr;

  logic       use_z;
  logic       m_shift, m_clear, m_en, m_store, m_busy, m_done;
  logic [2:0] m_sel;
  logic [7:0] m_tap;

  int n_checks = 0;
  int n_fail   = 0;

  int LENS [8] = '{3, 5, 9, 15, 27, 47, 81, 141};

  // Results gathered by collect().
  int pulse_q[$];
  int en_low_at;
  int n_shift, n_done, n_busy, n_clear, n_store;
  int first_shift, last_shift, last_done;
  int tap_err, sel_err, excl_err, exp_tap;
  int en_cnt [8];
  int store_seq[$];
  bit timed_out;

  always #5 clk = ~clk;

  wavelet_mac_scheduler dut_a (
    .clk(clk), .rst(rst), .i_data_clk(i_data_clk), .i_enable(i_enable),
    .o_shift(a_shift), .o_filter_sel(a_sel), .o_tap_idx(a_tap),
    .o_mac_clear(a_clear), .o_mac_en(a_en), .o_mac_store(a_store),
    .o_busy(a_busy), .o_frame_done(a_done), .o_overrun_count(a_ovr)
  );

  wavelet_mac_scheduler #(.FILTER_LENS(64'h0000_0000_0000_0300)) dut_z (
    .clk(clk), .rst(rst), .i_data_clk(i_data_clk), .i_enable(i_enable),
    .o_shift(z_shift), .o_filter_sel(z_sel), .o_tap_idx(z_tap),
    .o_mac_clear(z_clear), .o_mac_en(z_en), .o_mac_store(z_store),
    .o_busy(z_busy), .o_frame_done(z_done), .o_overrun_count(z_ovr)
  );

  assign m_shift = use_z ? z_shift : a_shift;
  assign m_clear = use_z ? z_clear : a_clear;
  assign m_en    = use_z ? z_en    : a_en;
  assign m_store = use_z ? z_store : a_store;
  assign m_busy  = use_z ? z_busy  : a_busy;
  assign m_done  = use_z ? z_done  : a_done;
  assign m_sel   = use_z ? z_sel   : a_sel;
  assign m_tap   = use_z ? z_tap   : a_tap;

  task automatic do_reset();
    rst        = 1'b1;
    i_data_clk = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs up to max_cyc cycles, driving 3-cycle strobe pulses at the offsets in
  // pulse_q, and records what the observed instance does until it has issued
  // stop_dones frame-done pulses.
  task automatic collect(input int stop_dones, input int max_cyc);
    bit hi;
    n_shift = 0; n_done = 0; n_busy = 0; n_clear = 0; n_store = 0;
    first_shift = -1; last_shift = -1; last_done = -1;
    tap_err = 0; sel_err = 0; excl_err = 0; exp_tap = 0;
    foreach (en_cnt[i]) en_cnt[i] = 0;
    store_seq.delete();
    for (int c = 0; c < max_cyc; c++) begin
      hi = 1'b0;
      foreach (pulse_q[i]) if (c >= pulse_q[i] && c < pulse_q[i] + 3) hi = 1'b1;
      i_data_clk = hi;
      if (en_low_at >= 0 && c == en_low_at) i_enable = 1'b0;
      @(negedge clk);
      if ((int'(m_shift) + int'(m_clear) + int'(m_en) + int'(m_store) + int'(m_done)) > 1) excl_err++;
      if (m_busy) n_busy++;
      if (m_shift) begin
        n_shift++;
        if (first_shift < 0) first_shift = c;
        last_shift = c;
      end
      if (m_clear) begin
        n_clear++;
        exp_tap = 0;
        if (m_sel != 3'(n_store % 8) || m_tap != 8'd0) sel_err++;
      end
      if (m_en) begin
        en_cnt[m_sel]++;
        if (m_tap != 8'(exp_tap)) tap_err++;
        if (m_sel != 3'(n_store % 8)) sel_err++;
        exp_tap++;
      end
      if (!m_clear && !m_en && !m_store && (m_sel != 3'd0 || m_tap != 8'd0)) sel_err++;
      if (m_store) begin
        store_seq.push_back(int'(m_sel));
        n_store++;
      end
      if (m_done) begin
        n_done++;
        last_done = c;
      end
      if (n_done >= stop_dones) break;
    end
    i_data_clk = 1'b0;
    timed_out  = (n_done < stop_dones);
  endtask

  function automatic int order_errs();
    int e = 0;
    foreach (store_seq[i]) if (store_seq[i] != i % 8) e++;
    return e;
  endfunction

  task automatic test_reset();
    logic [24:0] av, zv;
    rst = 1'b1; i_data_clk = 1'b0; i_enable = 1'b0; use_z = 1'b0;
    @(negedge clk);
    @(negedge clk);
    av = {a_shift, a_clear, a_en, a_store, a_done, a_busy, a_sel, a_tap, a_ovr};
    zv = {z_shift, z_clear, z_en, z_store, z_done, z_busy, z_sel, z_tap, z_ovr};
    n_checks++;
    if (av !== 25'd0) begin n_fail++; $display("FAIL reset_outputs_a: got %h want 0", av); end
    n_checks++;
    if (zv !== 25'd0) begin n_fail++; $display("FAIL reset_outputs_z: got %h want 0", zv); end
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    use_z = 1'b0; do_reset(); i_enable = 1'b1;
    pulse_q = '{0}; en_low_at = -1;
    collect(1, 800);
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL single_timeout: got %0d dones want 1", n_done); end
    n_checks++;
    if (n_shift !== 1) begin n_fail++; $display("FAIL single_shift_count: got %0d want 1", n_shift); end
    n_checks++;
    if (first_shift !== 3) begin n_fail++; $display("FAIL single_latency: shift at %0d want 3", first_shift); end
    n_checks++;
    if (n_store !== 8 || order_errs() !== 0) begin
      n_fail++; $display("FAIL single_store_order: %0d stores, %0d out of order, want 8 and 0", n_store, order_errs());
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (en_cnt[i] !== LENS[i]) begin n_fail++; $display("FAIL single_mac_count_f%0d: got %0d want %0d", i, en_cnt[i], LENS[i]); end
    end
    n_checks++;
    if (tap_err !== 0 || sel_err !== 0) begin n_fail++; $display("FAIL single_index: tap errs %0d sel errs %0d want 0", tap_err, sel_err); end
    n_checks++;
    if (excl_err !== 0) begin n_fail++; $display("FAIL single_exclusive: got %0d overlaps want 0", excl_err); end
    n_checks++;
    if (last_done - first_shift !== 345) begin n_fail++; $display("FAIL single_done_offset: got %0d want 345", last_done - first_shift); end
    n_checks++;
    if (n_busy !== 346) begin n_fail++; $display("FAIL single_frame_len: busy %0d cycles want 346", n_busy); end
    @(negedge clk);
    n_checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b0) begin n_fail++; $display("FAIL single_idle_after: busy %b done %b want 0 0", a_busy, a_done); end
  endtask

  task automatic test_overrun();
    use_z = 1'b0; do_reset(); i_enable = 1'b1;
    pulse_q = '{0, 100, 400}; en_low_at = -1;
    collect(2, 1200);
    n_checks++;
    if (n_shift !== 2 || last_shift !== 403) begin
      n_fail++; $display("FAIL overrun_shifts: got %0d shifts last at %0d want 2 at 403", n_shift, last_shift);
    end
    n_checks++;
    if (last_done !== 748) begin n_fail++; $display("FAIL overrun_done_cycle: got %0d want 748", last_done); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (en_cnt[i] !== 2 * LENS[i]) begin n_fail++; $display("FAIL overrun_mac_count_f%0d: got %0d want %0d", i, en_cnt[i], 2 * LENS[i]); end
    end
    n_checks++;
    if (n_store !== 16 || order_errs() !== 0 || tap_err !== 0) begin
      n_fail++; $display("FAIL overrun_frame_intact: stores %0d order errs %0d tap errs %0d want 16 0 0", n_store, order_errs(), tap_err);
    end
    n_checks++;
    if (a_ovr !== 8'd1) begin n_fail++; $display("FAIL overrun_count: got %0d want 1", a_ovr); end
  endtask

  task automatic test_saturation();
    int w;
    use_z = 1'b0; i_enable = 1'b1;
    for (int e = 0; e < 300; e++) begin
      i_data_clk = 1'b1;
      repeat (3) @(negedge clk);
      i_data_clk = 1'b0;
      repeat (3) @(negedge clk);
    end
    w = 0;
    while (a_busy && w < 400) begin @(negedge clk); w++; end
    n_checks++;
    if (a_busy !== 1'b0) begin n_fail++; $display("FAIL saturation_idle: busy %b after %0d cycles want 0", a_busy, w); end
    n_checks++;
    if (a_ovr !== 8'd255) begin n_fail++; $display("FAIL saturation_count: got %0d want 255", a_ovr); end
  endtask

  task automatic test_enable();
    use_z = 1'b0; do_reset(); i_enable = 1'b0;
    pulse_q = '{0}; en_low_at = -1;
    collect(1, 40);
    n_checks++;
    if (n_shift !== 0 || n_busy !== 0) begin n_fail++; $display("FAIL enable_gated: shifts %0d busy %0d want 0 0", n_shift, n_busy); end
    n_checks++;
    if (a_ovr !== 8'd0) begin n_fail++; $display("FAIL enable_no_count: got %0d want 0", a_ovr); end
    i_enable = 1'b1;
    pulse_q = '{0}; en_low_at = 50;
    collect(1, 800);
    en_low_at = -1;
    n_checks++;
    if (timed_out || last_done !== 348) begin n_fail++; $display("FAIL enable_mid_frame_done: done at %0d want 348", last_done); end
    n_checks++;
    if (en_cnt[7] !== 141 || n_store !== 8) begin n_fail++; $display("FAIL enable_mid_frame_work: f7 macs %0d stores %0d want 141 8", en_cnt[7], n_store); end
    i_enable = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    int hit, stray;
    bit saw5;
    logic [24:0] av;
    use_z = 1'b0; do_reset(); i_enable = 1'b1;
    hit = -1; saw5 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      i_data_clk = (c < 3);
      @(negedge clk);
      if (a_store && a_sel == 3'd5) saw5 = 1'b1;
      if (a_en && a_sel == 3'd5 && a_tap == 8'd20) begin hit = c; break; end
    end
    i_data_clk = 1'b0;
    n_checks++;
    if (hit !== 94) begin n_fail++; $display("FAIL rst_mid_position: f5 tap20 at %0d want 94", hit); end
    rst = 1'b1;
    @(negedge clk);
    av = {a_shift, a_clear, a_en, a_store, a_done, a_busy, a_sel, a_tap, a_ovr};
    n_checks++;
    if (av !== 25'd0) begin n_fail++; $display("FAIL rst_mid_outputs: got %h want 0", av); end
    rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (a_store || a_done || a_busy) stray++;
      if (a_store && a_sel == 3'd5) saw5 = 1'b1;
    end
    n_checks++;
    if (saw5 || stray !== 0) begin n_fail++; $display("FAIL rst_mid_no_store: f5 store %b stray cycles %0d want 0 0", saw5, stray); end
    pulse_q = '{0}; en_low_at = -1;
    collect(1, 800);
    n_checks++;
    if (first_shift !== 3 || n_store !== 8 || order_errs() !== 0 || en_cnt[5] !== 47) begin
      n_fail++; $display("FAIL rst_mid_clean_frame: shift %0d stores %0d order errs %0d f5 macs %0d want 3 8 0 47",
                         first_shift, n_store, order_errs(), en_cnt[5]);
    end
  endtask

  task automatic test_zero_length();
    use_z = 1'b1; do_reset(); i_enable = 1'b1;
    pulse_q = '{0}; en_low_at = -1;
    collect(1, 100);
    n_checks++;
    if (en_cnt[0] !== 0 || en_cnt[1] !== 3) begin n_fail++; $display("FAIL zero_len_macs: f0 %0d f1 %0d want 0 3", en_cnt[0], en_cnt[1]); end
    n_checks++;
    if (en_cnt[2] + en_cnt[3] + en_cnt[4] + en_cnt[5] + en_cnt[6] + en_cnt[7] !== 0) begin
      n_fail++; $display("FAIL zero_len_rest: got %0d macs want 0", en_cnt[2] + en_cnt[3] + en_cnt[4] + en_cnt[5] + en_cnt[6] + en_cnt[7]);
    end
    n_checks++;
    if (n_clear !== 8 || n_store !== 8 || order_errs() !== 0) begin
      n_fail++; $display("FAIL zero_len_clear_store: clears %0d stores %0d order errs %0d want 8 8 0", n_clear, n_store, order_errs());
    end
    n_checks++;
    if (n_busy !== 21 || first_shift !== 3 || last_done !== 23) begin
      n_fail++; $display("FAIL zero_len_frame: busy %0d shift %0d done %0d want 21 3 23", n_busy, first_shift, last_done);
    end
    n_checks++;
    if (tap_err !== 0 || sel_err !== 0) begin n_fail++; $display("FAIL zero_len_index: tap errs %0d sel errs %0d want 0", tap_err, sel_err); end
    use_z = 1'b0;
  endtask

  task automatic test_boundary();
    use_z = 1'b0; do_reset(); i_enable = 1'b1;
    pulse_q = '{0, 346, 351}; en_low_at = -1;
    collect(2, 1000);
    n_checks++;
    if (a_ovr !== 8'd1) begin n_fail++; $display("FAIL boundary_count: got %0d want 1", a_ovr); end
    n_checks++;
    if (n_shift !== 2 || last_shift !== 354) begin n_fail++; $display("FAIL boundary_next_frame: %0d shifts last at %0d want 2 at 354", n_shift, last_shift); end
    n_checks++;
    if (last_done !== 699 || n_store !== 16 || order_errs() !== 0) begin
      n_fail++; $display("FAIL boundary_frames: done %0d stores %0d order errs %0d want 699 16 0", last_done, n_store, order_errs());
    end
  endtask

  initial begin
    rst = 1'b1; i_data_clk = 1'b0; i_enable = 1'b0; use_z = 1'b0; en_low_at = -1;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_overrun();
    test_saturation();
    test_enable();
    test_reset_mid_run();
    test_zero_length();
    test_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
